window_addr_gen: RTL and testbench
==================================

// Module: window_addr_gen
// PURPOSE
//  Upstream address generator for the sequential router. Walks the output feature map in raster
//  order; for each output pixel, emits the KERNEL_SIZE x KERNEL_SIZE input addresses of its window
//  as one word (o_addr/o_valid/o_row_id -> router i_ag_addr/i_ag_valid/i_row_id).
//  Windows are issued in batches of ROUTER_COUNT, one per row router, then it waits for i_next.
// PARAMETERS
//  ROUTER_COUNT  4  row routers per batch; o_row_id cycles 0..ROUTER_COUNT-1
//  ADDR_WIDTH    8  SRAM element address width
//  KERNEL_SIZE   3  window side; localparam ADDR_LENGTH = KERNEL_SIZE*KERNEL_SIZE (=9)
// PORTS
//  i_clk         in   1                           clock
//  i_nrst        in   1                           async active-low reset
//  i_reg_clear   in   1                           sync clear to IDLE, same effect as reset
//  i_start       in   1                           pulse: begin walk (ignored unless IDLE or DONE)
//  i_i_size      in   ADDR_WIDTH                  input map side (square, row-major, 1 elem/addr)
//  i_o_size      in   ADDR_WIDTH                  output map side
//  i_stride      in   ADDR_WIDTH                  window stride
//  i_next        in   1                           pulse: routers drained, release next batch
//  o_addr        out  [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0]  window addresses, ky-major then kx
//  o_valid       out  1                           o_addr/o_row_id valid this cycle
//  o_row_id      out  ROUTER_COUNT                target row router index (binary)
//  o_batch_done  out  1                           high in WAIT (batch issued, awaiting i_next)
//  o_done        out  1                           high in DONE until i_start/i_reg_clear/reset
// BEHAVIOUR
//  - Reset/i_reg_clear: state IDLE; all outputs and counters (ox, oy, slot) = 0.
//  - Config sampled into registers on accepted i_start; inputs may change afterwards.
//  - FSM: IDLE --i_start--> GEN; GEN --slot==ROUTER_COUNT-1 & not last--> WAIT;
//    GEN --last pixel issued--> DONE; WAIT --i_next--> GEN; DONE --i_start--> GEN (restart at 0,0).
//  - i_start with i_o_size==0 or i_i_size==0: IDLE/DONE -> DONE directly, no o_valid.
//  - GEN issues exactly one window per cycle, all outputs registered; first o_valid is the cycle
//    after i_start is sampled (1-cycle latency), and likewise the cycle after i_next in WAIT.
//  - Window (ox,oy): base = (oy*stride)*i_size + ox*stride;
//    o_addr[ky*K+kx] = base + ky*i_size + kx. Computed at 2*ADDR_WIDTH, truncated to ADDR_WIDTH
//    (modulo 2^ADDR_WIDTH, no saturation, no error flag).
//  - o_row_id = slot; slot increments per window, resets to 0 on entering WAIT/DONE.
//  - ox increments per window; at ox==o_size-1 wraps to 0 and oy increments.
//    Last pixel = (o_size-1, o_size-1); its batch may be partial (slot < ROUTER_COUNT-1).
//  - o_valid is 0 in IDLE/WAIT/DONE; o_addr/o_row_id hold last values when o_valid=0.
//  - i_next outside WAIT ignored; i_start outside IDLE/DONE ignored.
//  - i_reg_clear has priority over i_start/i_next in the same cycle.
//  - Reset or i_reg_clear mid-GEN aborts immediately; o_valid low the next cycle, no partial batch.
//  - o_batch_done/o_done are registered state decodes (high the cycle the state is entered).
// TESTING
//  1 i_size=4,o_size=2,stride=1,start -> 4 valid cycles: row0 {0,1,2,4,5,6,8,9,10},
//    row1 base 1, row2 base 4 {4,5,6,8,9,10,12,13,14}, row3 base 5; then o_done, no o_batch_done.
//  2 i_size=5,o_size=2,stride=2 -> row1 {2,3,4,7,8,9,12,13,14}, row2 base 10, row3 base 12.
//  3 i_size=5,o_size=3,stride=1 -> batches 4,4,1 windows; o_batch_done after 1st/2nd; holds
//    (no o_valid) 10 cycles without i_next; last window row_id 0 base 12; then o_done.
//  4 i_size=20,o_size=18,stride=1 -> last window base 357 mod 256 = 101; o_addr[8] = 143.
//  5 Assert i_nrst low (then i_reg_clear, separately) during 2nd window of a batch
//    -> all outputs 0, IDLE; restart gives row0 base 0.
//  6 o_size=0 start -> o_done next cycle, no o_valid; i_start/i_next while in GEN -> no effect.

Source files
------------

// File: rtl/window_addr_gen.sv
// Window address generator: walks the output map in raster order and issues one
// KERNEL_SIZE x KERNEL_SIZE window of input addresses per cycle, in batches of ROUTER_COUNT.
//
// state  | meaning
// IDLE   | after reset/clear, waiting for i_start
// GEN    | issuing one window per cycle
// WAIT   | batch issued, waiting for i_next
// DONE   | last pixel issued (or empty map), waiting for i_start
module window_addr_gen #(
  parameter int ROUTER_COUNT = 4,
  parameter int ADDR_WIDTH   = 8,
  parameter int KERNEL_SIZE  = 3
) (
  input  logic                                                  i_clk,
  input  logic                                                  i_nrst,
  input  logic                                                  i_reg_clear,
  input  logic                                                  i_start,
  input  logic [ADDR_WIDTH-1:0]                                 i_i_size,
  input  logic [ADDR_WIDTH-1:0]                                 i_o_size,
  input  logic [ADDR_WIDTH-1:0]                                 i_stride,
  input  logic                                                  i_next,
  output logic [0:KERNEL_SIZE*KERNEL_SIZE-1][ADDR_WIDTH-1:0]    o_addr,
  output logic                                                  o_valid,
  output logic [ROUTER_COUNT-1:0]                               o_row_id,
  output logic                                                  o_batch_done,
  output logic                                                  o_done
);

  localparam int ADDR_LENGTH = KERNEL_SIZE * KERNEL_SIZE;
  localparam int AW2         = 2 * ADDR_WIDTH;
  localparam int SW          = $clog2(ROUTER_COUNT + 1);

  typedef enum logic [1:0] {S_IDLE, S_GEN, S_WAIT, S_DONE} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   i_size_r, o_size_r, stride_r;
  logic [ADDR_WIDTH-1:0]   ox, oy;
  logic [SW-1:0]           slot;
  logic                    last_r;

  logic                    idle_like, zero_cfg, issue, win_last;
  logic [ADDR_WIDTH-1:0]   cfg_i, cfg_o, cfg_s, win_ox, win_oy, o_max;
  logic [AW2-1:0]          base, sum;
  logic [0:ADDR_LENGTH-1][ADDR_WIDTH-1:0] addr_nx;

  // On an accepted start the first window is built straight from the inputs,
  // since the config registers only load on that same edge.
  always_comb begin
    idle_like = (state == S_IDLE) || (state == S_DONE);
    zero_cfg  = (i_o_size == '0) || (i_i_size == '0);
    cfg_i     = i_size_r;
    cfg_o     = o_size_r;
    cfg_s     = stride_r;
    win_ox    = ox;
    win_oy    = oy;
    if (idle_like) begin
      cfg_i  = i_i_size;
      cfg_o  = i_o_size;
      cfg_s  = i_stride;
      win_ox = '0;
      win_oy = '0;
    end
    o_max    = cfg_o - ADDR_WIDTH'(1);
    win_last = (win_ox == o_max) && (win_oy == o_max);
    base     = (AW2'(win_oy) * AW2'(cfg_s)) * AW2'(cfg_i) + AW2'(win_ox) * AW2'(cfg_s);
    sum      = '0;
    addr_nx  = '0;
    for (int ky = 0; ky < KERNEL_SIZE; ky++) begin
      for (int kx = 0; kx < KERNEL_SIZE; kx++) begin
        sum = base + AW2'(ky) * AW2'(cfg_i) + AW2'(kx);
        addr_nx[ky*KERNEL_SIZE+kx] = sum[ADDR_WIDTH-1:0];
      end
    end
    issue = (idle_like && i_start && !zero_cfg)
         || (state == S_GEN && !last_r && slot != SW'(ROUTER_COUNT))
         || (state == S_WAIT && i_next);
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state        <= S_IDLE;
      i_size_r     <= '0;
      o_size_r     <= '0;
      stride_r     <= '0;
      ox           <= '0;
      oy           <= '0;
      slot         <= '0;
      last_r       <= 1'b0;
      o_addr       <= '0;
      o_valid      <= 1'b0;
      o_row_id     <= '0;
      o_batch_done <= 1'b0;
      o_done       <= 1'b0;
    end else if (i_reg_clear) begin
      state        <= S_IDLE;
      i_size_r     <= '0;
      o_size_r     <= '0;
      stride_r     <= '0;
      ox           <= '0;
      oy           <= '0;
      slot         <= '0;
      last_r       <= 1'b0;
      o_addr       <= '0;
      o_valid      <= 1'b0;
      o_row_id     <= '0;
      o_batch_done <= 1'b0;
      o_done       <= 1'b0;
    end else begin
      if (issue) begin
        o_valid  <= 1'b1;
        o_addr   <= addr_nx;
        o_row_id <= ROUTER_COUNT'(slot);
        slot     <= slot + 1'b1;
        last_r   <= win_last;
        if (win_ox == o_max) begin
          ox <= '0;
          oy <= win_oy + 1'b1;
        end else begin
          ox <= win_ox + 1'b1;
          oy <= win_oy;
        end
      end else begin
        o_valid <= 1'b0;
      end

      case (state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            if (zero_cfg) begin
              state  <= S_DONE;
              o_done <= 1'b1;
            end else begin
              state    <= S_GEN;
              o_done   <= 1'b0;
              i_size_r <= i_i_size;
              o_size_r <= i_o_size;
              stride_r <= i_stride;
            end
          end
        end
        S_GEN: begin
          // last-pixel check wins so a full final batch goes to DONE, not WAIT
          if (last_r) begin
            state  <= S_DONE;
            o_done <= 1'b1;
            slot   <= '0;
            ox     <= '0;
            oy     <= '0;
            last_r <= 1'b0;
          end else if (slot == SW'(ROUTER_COUNT)) begin
            state        <= S_WAIT;
            o_batch_done <= 1'b1;
            slot         <= '0;
          end
        end
        S_WAIT: begin
          if (i_next) begin
            state        <= S_GEN;
            o_batch_done <= 1'b0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_window_addr_gen.sv
// Directed bench for window_addr_gen: hand-computed window bases and vectors,
// checked with immediate assertions.
module tb_window_addr_gen;
  localparam int AW = 8;
  localparam int RC = 4;
  localparam int K  = 3;
  localparam int AL = K * K;

  logic                     i_clk = 1'b0;
  logic                     i_nrst = 1'b0;
  logic                     i_reg_clear = 1'b0;
  logic                     i_start = 1'b0;
  logic                     i_next = 1'b0;
  logic [AW-1:0]            i_i_size = '0;
  logic [AW-1:0]            i_o_size = '0;
  logic [AW-1:0]            i_stride = '0;
  logic [0:AL-1][AW-1:0]    o_addr;
  logic                     o_valid;
  logic [RC-1:0]            o_row_id;
  logic                     o_batch_done;
  logic                     o_done;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 i_clk = ~i_clk;

  window_addr_gen #(.ROUTER_COUNT(RC), .ADDR_WIDTH(AW), .KERNEL_SIZE(K)) dut (
    .i_clk        (i_clk),
    .i_nrst       (i_nrst),
    .i_reg_clear  (i_reg_clear),
    .i_start      (i_start),
    .i_i_size     (i_i_size),
    .i_o_size     (i_o_size),
    .i_stride     (i_stride),
    .i_next       (i_next),
    .o_addr       (o_addr),
    .o_valid      (o_valid),
    .o_row_id     (o_row_id),
    .o_batch_done (o_batch_done),
    .o_done       (o_done)
  );

  function automatic logic [0:AL-1][AW-1:0] win(input int base, input int isz);
    logic [0:AL-1][AW-1:0] w;
    for (int ky = 0; ky < K; ky++)
      for (int kx = 0; kx < K; kx++)
        w[ky*K+kx] = AW'(base + ky * isz + kx);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_win(input string tag, input int base, input int isz, input int row);
    chk({tag, "_valid"}, 128'(o_valid), 128'(1));
    chk({tag, "_addr"}, 128'(o_addr), 128'(win(base, isz)));
    chk({tag, "_row"}, 128'(o_row_id), 128'(row));
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_valid"}, 128'(o_valid), 128'(0));
    chk({tag, "_addr"}, 128'(o_addr), 128'(0));
    chk({tag, "_row"}, 128'(o_row_id), 128'(0));
    chk({tag, "_bdone"}, 128'(o_batch_done), 128'(0));
    chk({tag, "_done"}, 128'(o_done), 128'(0));
  endtask

  task automatic start_run(input int isz, input int osz, input int str);
    i_i_size = AW'(isz);
    i_o_size = AW'(osz);
    i_stride = AW'(str);
    i_start  = 1'b1;
    tick();
    i_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int max);
    int n;
    n = 0;
    while (!o_done && n < max) begin
      tick();
      n++;
    end
    chk(tag, 128'(o_done), 128'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int hold_bad;
    int cnt;
    logic [0:AL-1][AW-1:0] last_addr;
    logic [RC-1:0]         last_row;

    // reset
    tick();
    tick();
    chk_idle("rst");
    i_nrst = 1'b1;
    tick();
    chk_idle("rst_rel");

    // T1: 4x4 input, 2x2 output, stride 1: one full batch that is also the last
    start_run(4, 2, 1);
    chk("t1_w0_vec", 128'(o_addr), 128'({8'd0, 8'd1, 8'd2, 8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10}));
    chk_win("t1_w0", 0, 4, 0);
    tick(); chk_win("t1_w1", 1, 4, 1);
    tick();
    chk("t1_w2_vec", 128'(o_addr), 128'({8'd4, 8'd5, 8'd6, 8'd8, 8'd9, 8'd10, 8'd12, 8'd13, 8'd14}));
    chk_win("t1_w2", 4, 4, 2);
    tick(); chk_win("t1_w3", 5, 4, 3);
    tick();
    chk("t1_end_valid", 128'(o_valid), 128'(0));
    chk("t1_end_done", 128'(o_done), 128'(1));
    chk("t1_end_bdone", 128'(o_batch_done), 128'(0));
    chk("t1_hold_addr", 128'(o_addr), 128'(win(5, 4)));
    chk("t1_hold_row", 128'(o_row_id), 128'(3));

    // T2: stride 2, restart from DONE; config changed after start must not matter
    start_run(5, 2, 2);
    i_i_size = 8'd99; i_o_size = 8'd7; i_stride = 8'd3;
    chk("t2_done_low", 128'(o_done), 128'(0));
    chk_win("t2_w0", 0, 5, 0);
    tick();
    chk("t2_w1_vec", 128'(o_addr), 128'({8'd2, 8'd3, 8'd4, 8'd7, 8'd8, 8'd9, 8'd12, 8'd13, 8'd14}));
    chk_win("t2_w1", 2, 5, 1);
    tick(); chk_win("t2_w2", 10, 5, 2);
    tick(); chk_win("t2_w3", 12, 5, 3);
    tick(); chk("t2_done", 128'(o_done), 128'(1));

    // T3: 3x3 output -> batches of 4, 4, 1
    start_run(5, 3, 1);
    chk_win("t3_b0w0", 0, 5, 0);
    tick(); chk_win("t3_b0w1", 1, 5, 1);
    tick(); chk_win("t3_b0w2", 2, 5, 2);
    tick(); chk_win("t3_b0w3", 5, 5, 3);
    tick();
    chk("t3_b0_bdone", 128'(o_batch_done), 128'(1));
    chk("t3_b0_valid", 128'(o_valid), 128'(0));
    hold_bad = 0;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (o_valid || !o_batch_done) hold_bad++;
    end
    chk("t3_hold", 128'(hold_bad), 128'(0));
    i_next = 1'b1; tick(); i_next = 1'b0;
    chk_win("t3_b1w0", 6, 5, 0);
    chk("t3_b1_bdone_low", 128'(o_batch_done), 128'(0));
    i_start = 1'b1; i_next = 1'b1;
    tick();
    i_start = 1'b0; i_next = 1'b0;
    chk_win("t3_b1w1_ign", 7, 5, 1);
    tick(); chk_win("t3_b1w2", 10, 5, 2);
    tick(); chk_win("t3_b1w3", 11, 5, 3);
    tick(); chk("t3_b1_bdone", 128'(o_batch_done), 128'(1));
    i_next = 1'b1; tick(); i_next = 1'b0;
    chk_win("t3_b2w0", 12, 5, 0);
    tick();
    chk("t3_done", 128'(o_done), 128'(1));
    chk("t3_end_bdone", 128'(o_batch_done), 128'(0));
    chk("t3_end_valid", 128'(o_valid), 128'(0));

    // T4: 20x20 input, 18x18 output -> address wrap on the last window
    start_run(20, 18, 1);
    cnt = 0;
    last_addr = '0;
    last_row = '0;
    for (int c = 0; c < 2000 && !o_done; c++) begin
      if (o_valid) begin
        cnt++;
        last_addr = o_addr;
        last_row  = o_row_id;
      end
      i_next = o_batch_done;
      tick();
    end
    i_next = 1'b0;
    chk("t4_done", 128'(o_done), 128'(1));
    chk("t4_count", 128'(cnt), 128'(324));
    chk("t4_last_a0", 128'(last_addr[0]), 128'(101));
    chk("t4_last_a8", 128'(last_addr[8]), 128'(143));
    chk("t4_last_vec", 128'(last_addr), 128'(win(357, 20)));
    chk("t4_last_row", 128'(last_row), 128'(3));

    // T5: async reset, then sync clear (with simultaneous start), mid-batch
    start_run(4, 2, 1);
    tick(); chk_win("t5_pre", 1, 4, 1);
    i_nrst = 1'b0;
    #1;
    chk_idle("t5_rst_async");
    tick();
    chk_idle("t5_rst_held");
    i_nrst = 1'b1;
    tick();
    chk("t5_rst_idle", 128'(o_valid), 128'(0));
    start_run(4, 2, 1);
    chk_win("t5_restart", 0, 4, 0);
    tick();
    i_reg_clear = 1'b1; i_start = 1'b1;
    tick();
    i_reg_clear = 1'b0; i_start = 1'b0;
    chk_idle("t5_clr");
    tick();
    chk_idle("t5_clr_idle");
    start_run(4, 2, 1);
    chk_win("t5_restart2", 0, 4, 0);
    wait_done("t5_done", 20);

    // T6: empty maps go straight to DONE
    i_reg_clear = 1'b1; tick(); i_reg_clear = 1'b0;
    chk("t6_clr_done", 128'(o_done), 128'(0));
    start_run(4, 0, 1);
    chk("t6_osz0_done", 128'(o_done), 128'(1));
    chk("t6_osz0_valid", 128'(o_valid), 128'(0));
    tick();
    chk("t6_osz0_valid2", 128'(o_valid), 128'(0));
    i_reg_clear = 1'b1; tick(); i_reg_clear = 1'b0;
    start_run(0, 3, 1);
    chk("t6_isz0_done", 128'(o_done), 128'(1));
    chk("t6_isz0_valid", 128'(o_valid), 128'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
